// File: rtl/bsg_manycore_pkg.sv
// Shared types for the manycore store tracker.
//   - ret packet width macro and packed return-packet struct macro
//     (struct fields depend on module parameters, so it is declared via macro)
//   - fence FSM state enum
`ifndef BSG_MANYCORE_PKG_SV
`define BSG_MANYCORE_PKG_SV

`define BSG_MANYCORE_RET_PACKET_WIDTH(x_cord_width, y_cord_width) \
  (bsg_manycore_pkg::ret_op_width_gp + (x_cord_width) + (y_cord_width))

`define DECLARE_BSG_MANYCORE_RET_PACKET_S(x_cord_width, y_cord_width) \
  typedef struct packed { \
    logic [bsg_manycore_pkg::ret_op_width_gp-1:0] op; \
    logic [(y_cord_width)-1:0] y_cord; \
    logic [(x_cord_width)-1:0] x_cord; \
  } bsg_manycore_ret_packet_s

package bsg_manycore_pkg;

  localparam int unsigned ret_op_width_gp = 5;

  typedef enum logic [1:0] {
    eIdle,
    eWait,
    eDone
  } fence_state_e;

endpackage

`endif

// File: rtl/bsg_counter_up_down_sat.sv
// Saturating up/down counter.
//   clk_i, reset_n_i : clock, async active-low reset
//   up_i, down_i     : increment / decrement requests (both -> hold)
//   count_o          : current count, 0..max_val_p
//   overflow_o       : up-only request while at max_val_p (count holds)
//   underflow_o      : down-only request while at 0 (count holds)
module bsg_counter_up_down_sat #(
  parameter int unsigned width_p   = 5,
  parameter int unsigned max_val_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o,
  output logic               overflow_o,
  output logic               underflow_o
);

  logic at_max, at_zero;

  assign at_max      = (count_o == width_p'(max_val_p));
  assign at_zero     = (count_o == '0);
  assign overflow_o  = up_i & ~down_i & at_max;
  assign underflow_o = down_i & ~up_i & at_zero;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_o <= '0;
    end else if (up_i & ~down_i & ~at_max) begin
      count_o <= count_o + 1'b1;
    end else if (down_i & ~up_i & ~at_zero) begin
      count_o <= count_o - 1'b1;
    end
  end

endmodule

// File: rtl/bsg_manycore_store_tracker.sv
// Tracks remote stores issued by this tile and not yet acknowledged.
//   out_v_i/out_ready_i/out_is_store_i : outbound handshake; accepted stores count up
//   credit_avail_o  : below credit limit and no fence waiting
//   ret_v_i/ret_data_i/ret_ready_o : return network (always accepted); matching
//                     packets ({op==0, y==my_y_i, x==my_x_i}) retire a store
//   fence_v_i/fence_done_o : store fence request (level) / one-cycle completion
//   cnt_rd_v_i/cnt_rv_o/cnt_data_o : 1-cycle-latency read of the outstanding count
//   error_o         : sticky; overflow, underflow or mismatched return packet
module bsg_manycore_store_tracker
  import bsg_manycore_pkg::*;
#(
  parameter int unsigned x_cord_width_p = 4,
  parameter int unsigned y_cord_width_p = 4,
  parameter int unsigned data_width_p   = 32,
  parameter int unsigned max_out_p      = 16,
  localparam int unsigned ret_packet_width_lp =
    `BSG_MANYCORE_RET_PACKET_WIDTH(x_cord_width_p, y_cord_width_p),
  localparam int unsigned cnt_width_lp = $clog2(max_out_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           out_v_i,
  input  logic                           out_ready_i,
  input  logic                           out_is_store_i,
  output logic                           credit_avail_o,
  input  logic                           ret_v_i,
  input  logic [ret_packet_width_lp-1:0] ret_data_i,
  output logic                           ret_ready_o,
  input  logic [x_cord_width_p-1:0]      my_x_i,
  input  logic [y_cord_width_p-1:0]      my_y_i,
  input  logic                           fence_v_i,
  output logic                           fence_done_o,
  input  logic                           cnt_rd_v_i,
  output logic                           cnt_rv_o,
  output logic [data_width_p-1:0]        cnt_data_o,
  output logic                           error_o
);

  `DECLARE_BSG_MANYCORE_RET_PACKET_S(x_cord_width_p, y_cord_width_p);

  bsg_manycore_ret_packet_s ret_pkt;
  logic                     issue, ret_match, ret_bad;
  logic                     overflow, underflow;
  logic [cnt_width_lp-1:0]  count;
  fence_state_e             state_r, state_n;

  assign ret_pkt     = ret_data_i;
  assign ret_ready_o = 1'b1;

  assign issue     = out_v_i & out_ready_i & out_is_store_i;
  assign ret_match = ret_v_i & (ret_pkt.x_cord == my_x_i)
                             & (ret_pkt.y_cord == my_y_i)
                             & (ret_pkt.op == '0);
  assign ret_bad   = ret_v_i & ~ret_match;

  bsg_counter_up_down_sat #(
    .width_p   (cnt_width_lp),
    .max_val_p (max_out_p)
  ) counter (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .up_i        (issue),
    .down_i      (ret_match),
    .count_o     (count),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  // Derived from registered count/state only, so no path from out_v_i.
  assign credit_avail_o = (count < cnt_width_lp'(max_out_p)) & (state_r != eWait);
  assign fence_done_o   = (state_r == eDone);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eIdle;
    end else begin
      state_r <= state_n;
    end
  end

  // WAIT checks the registered count, so a final retire is seen one cycle later.
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      eIdle:   if (fence_v_i) state_n = eWait;
      eWait:   if ((count == '0) && !issue) state_n = eDone;
      eDone:   state_n = eIdle;
      default: state_n = eIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_rv_o   <= 1'b0;
      cnt_data_o <= '0;
      error_o    <= 1'b0;
    end else begin
      cnt_rv_o <= cnt_rd_v_i;
      if (cnt_rd_v_i) begin
        cnt_data_o <= data_width_p'(count);
      end
      error_o <= error_o | overflow | underflow | ret_bad;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_store_tracker.sv
module tb_bsg_manycore_store_tracker;

  localparam int unsigned xw_lp  = 4;
  localparam int unsigned yw_lp  = 4;
  localparam int unsigned dw_lp  = 32;
  localparam int unsigned max_lp = 8;
  localparam int unsigned rw_lp  = 5 + xw_lp + yw_lp;

  logic             clk_i = 1'b0;
  logic             reset_n_i = 1'b0;
  logic             out_v_i, out_ready_i, out_is_store_i;
  logic             credit_avail_o;
  logic             ret_v_i;
  logic [rw_lp-1:0] ret_data_i;
  logic             ret_ready_o;
  logic [xw_lp-1:0] my_x_i;
  logic [yw_lp-1:0] my_y_i;
  logic             fence_v_i, fence_done_o;
  logic             cnt_rd_v_i, cnt_rv_o;
  logic [dw_lp-1:0] cnt_data_o;
  logic             error_o;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  localparam logic [rw_lp-1:0] good_ret_lp = {5'b0, 4'h5, 4'h3};
  localparam logic [rw_lp-1:0] badx_ret_lp = {5'b0, 4'h5, 4'h4};

  bsg_manycore_store_tracker #(
    .x_cord_width_p (xw_lp),
    .y_cord_width_p (yw_lp),
    .data_width_p   (dw_lp),
    .max_out_p      (max_lp)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .out_v_i        (out_v_i),
    .out_ready_i    (out_ready_i),
    .out_is_store_i (out_is_store_i),
    .credit_avail_o (credit_avail_o),
    .ret_v_i        (ret_v_i),
    .ret_data_i     (ret_data_i),
    .ret_ready_o    (ret_ready_o),
    .my_x_i         (my_x_i),
    .my_y_i         (my_y_i),
    .fence_v_i      (fence_v_i),
    .fence_done_o   (fence_done_o),
    .cnt_rd_v_i     (cnt_rd_v_i),
    .cnt_rv_o       (cnt_rv_o),
    .cnt_data_o     (cnt_data_o),
    .error_o        (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    out_v_i = 0; out_ready_i = 0; out_is_store_i = 0;
    ret_v_i = 0; ret_data_i = '0; fence_v_i = 0; cnt_rd_v_i = 0;
  endtask

  task automatic drive_issue(input logic on);
    out_v_i = on; out_ready_i = on; out_is_store_i = on;
  endtask

  task automatic drive_ret(input logic on, input logic [rw_lp-1:0] pkt);
    ret_v_i = on; ret_data_i = pkt;
  endtask

  // Called at posedge+1; reset pulse falls entirely between clock edges.
  task automatic do_reset();
    idle_inputs();
    #2 reset_n_i = 0;
    #2;
    check("rst_credit", credit_avail_o, 1);
    check("rst_ready",  ret_ready_o, 1);
    check("rst_done",   fence_done_o, 0);
    check("rst_rv",     cnt_rv_o, 0);
    check("rst_data",   cnt_data_o, 0);
    check("rst_err",    error_o, 0);
    #2 reset_n_i = 1;
  endtask

  task automatic read_cnt(input string tag, input logic [31:0] exp);
    cnt_rd_v_i = 1;
    step();
    cnt_rd_v_i = 0;
    check({tag, "_rv"}, cnt_rv_o, 1);
    check(tag, cnt_data_o, exp);
  endtask

  task automatic issue_n(input int unsigned n);
    drive_issue(1);
    for (int unsigned i = 0; i < n; i++) step();
    drive_issue(0);
  endtask

  initial begin
    my_x_i = 4'h3;
    my_y_i = 4'h5;
    idle_inputs();
    step();
    do_reset();

    // 1: three issues then three returns, read every cycle (data lags count by 1)
    cnt_rd_v_i = 1;
    drive_issue(1);
    step(); check("t1_d0", cnt_data_o, 0); check("t1_cr0", credit_avail_o, 1);
    step(); check("t1_d1", cnt_data_o, 1);
    step(); check("t1_d2", cnt_data_o, 2); check("t1_cr1", credit_avail_o, 1);
    drive_issue(0);
    drive_ret(1, good_ret_lp);
    step(); check("t1_d3", cnt_data_o, 3);
    step(); check("t1_d4", cnt_data_o, 2);
    step(); check("t1_d5", cnt_data_o, 1); check("t1_cr2", credit_avail_o, 1);
    drive_ret(0, '0);
    step(); check("t1_d6", cnt_data_o, 0); check("t1_err", error_o, 0);
    cnt_rd_v_i = 0;

    // 2: fill to the limit, free one credit, refill, then force an overflow
    issue_n(max_lp - 1);
    check("t2_cr_7", credit_avail_o, 1);
    issue_n(1);
    check("t2_cr_8", credit_avail_o, 0);
    drive_ret(1, good_ret_lp);
    step();
    drive_ret(0, '0);
    check("t2_cr_ret", credit_avail_o, 1);
    issue_n(1);
    check("t2_cr_full", credit_avail_o, 0);
    check("t2_err0", error_o, 0);
    issue_n(1);
    check("t2_err_ovf", error_o, 1);
    read_cnt("t2_cnt", max_lp);

    // 3: fence with two outstanding stores
    step();
    do_reset();
    issue_n(2);
    fence_v_i = 1;
    step();
    check("t3_cr_wait", credit_avail_o, 0);
    check("t3_done0", fence_done_o, 0);
    drive_ret(1, good_ret_lp);
    step(); check("t3_done1", fence_done_o, 0);
    step(); check("t3_done2", fence_done_o, 0);
    drive_ret(0, '0);
    step(); check("t3_done_pulse", fence_done_o, 1); check("t3_cr_done", credit_avail_o, 1);
    fence_v_i = 0;
    step(); check("t3_done_low", fence_done_o, 0); check("t3_cr_after", credit_avail_o, 1);
    check("t3_err", error_o, 0);

    // 4: simultaneous issue+retire, then a return with the wrong x
    issue_n(1);
    drive_issue(1);
    drive_ret(1, good_ret_lp);
    step();
    drive_issue(0);
    drive_ret(0, '0);
    read_cnt("t4_cnt_both", 1);
    check("t4_err0", error_o, 0);
    drive_ret(1, badx_ret_lp);
    step();
    drive_ret(0, '0);
    check("t4_err_badx", error_o, 1);
    read_cnt("t4_cnt_badx", 1);
    step();
    check("t4_err_sticky", error_o, 1);

    // 5: read concurrent with a retire sees the pre-retire count
    step();
    do_reset();
    issue_n(5);
    cnt_rd_v_i = 1;
    drive_ret(1, good_ret_lp);
    step();
    drive_ret(0, '0);
    check("t5_rv0", cnt_rv_o, 1);
    check("t5_d0", cnt_data_o, 5);
    step();
    cnt_rd_v_i = 0;
    check("t5_d1", cnt_data_o, 4);
    step();
    check("t5_rv_low", cnt_rv_o, 0);
    check("t5_hold", cnt_data_o, 4);

    // 6: async reset while the fence waits on 3 stores
    step();
    do_reset();
    issue_n(3);
    read_cnt("t6_cnt3", 3);
    drive_ret(1, badx_ret_lp);
    fence_v_i = 1;
    step();
    drive_ret(0, '0);
    check("t6_cr_wait", credit_avail_o, 0);
    check("t6_err_pre", error_o, 1);
    #2 reset_n_i = 0;
    #1;
    check("t6_cr_rst", credit_avail_o, 1);
    check("t6_done_rst", fence_done_o, 0);
    check("t6_data_rst", cnt_data_o, 0);
    check("t6_err_rst", error_o, 0);
    fence_v_i = 0;
    #2 reset_n_i = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_no_done", fence_done_o, 0);
    end
    read_cnt("t6_cnt0", 0);
    drive_ret(1, good_ret_lp);
    step();
    drive_ret(0, '0);
    check("t6_late_ret_err", error_o, 1);
    read_cnt("t6_cnt_hold0", 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
